cpu_controller: RTL and testbench
=================================

# cpu_controller

Sequencing state machine for the simple RISC datapath. It sits directly downstream of the instruction decoder and consumes the decoder's 5-bit `{opcode, op}` field. It drives the decoder's 3-bit one-hot register-number select (`nsel`) and every load, select and write strobe of the register file, the A/B/C pipeline registers and the status register. It executes one instruction per `s` pulse and raises `w` when idle.

## Interface
Parameters: none.

Ports:
- `clk` — input, 1 — rising-edge clock.
- `rst_n` — input, 1 — asynchronous, active-low reset.
- `s` — input, 1 — start; sampled only in WAIT.
- `fsm_in` — input, 5 — `{opcode[2:0], op[1:0]}` from the instruction decoder.
- `w` — output, 1 — idle / ready for `s`.
- `nsel` — output, 3 — one-hot register select to the decoder:
  - `001` selects Rm; `010` selects Rd; `100` selects Rn; `000` means none.
- `vsel` — output, 2 — register-file write source: `00` = C, `10` = sximm8 (`01`/`11` are never driven).
- `write` — output, 1 — register-file write enable.
- `loada`, `loadb`, `loadc`, `loads` — output, 1 each — load enables for register A, register B, register C and the status register.
- `asel` — output, 1 — `1` forces the ALU A input to 0.
- `bsel` — output, 1 — `1` selects sximm5 for the ALU B input (always 0 in this ISA subset).
- `illegal` — output, 1 — present only with `CTRL_ILLEGAL_FLAG_EN`.

## Operation
- Moore machine. All outputs decode from the state register alone. Any output not listed for a state is 0.
- Internal 5-bit `ir_op` register. It captures `fsm_in` on the WAIT→DECODE edge. All later decisions use `ir_op`, so `fsm_in` may change after capture.
- Supported `ir_op` values (`opcode_op`):
  - `110_10` MOV imm
  - `110_00` MOV reg
  - `101_00` ADD
  - `101_01` CMP
  - `101_10` AND
  - `101_11` MVN
- States, their outputs, and next state:
  - **WAIT**: `w`=1. Goes to DECODE if `s`=1, else stays in WAIT.
  - **DECODE**: no strobes. Next state:
    - MOV imm → WR_IMM.
    - ADD, CMP or AND → GET_A.
    - MOV reg or MVN → GET_B.
    - Any other value → WAIT.
  - **WR_IMM**: `nsel`=100, `vsel`=10, `write`=1. Goes to WAIT.
  - **GET_A**: `nsel`=100, `loada`=1. Goes to GET_B.
  - **GET_B**: `nsel`=001, `loadb`=1. Goes to ALU.
  - **ALU**: `loadc`=1.
    - `asel`=1 for MOV reg and MVN; `asel`=0 otherwise.
    - `loads`=1 only for CMP.
    - Goes to WAIT if CMP, else to WR_REG.
  - **WR_REG**: `nsel`=010, `vsel`=00, `write`=1. Goes to WAIT.
- Illegal `ir_op`: no strobe is asserted. The machine spends one cycle in DECODE, then returns to WAIT.
- While `w`=0, `s` is ignored. A held `s` re-triggers only after the machine returns to WAIT.

## Timing
- Reset (`rst_n`=0):
  - Takes effect asynchronously.
  - State → WAIT, `ir_op` → `00000`.
  - Outputs: `w`=1, `nsel`=000, `vsel`=00, every other output 0, `illegal`=0.
  - Reset mid-instruction abandons it. Any strobe already in progress drops immediately, with no partial write after reset.
- Release: the first edge with `rst_n`=1 and `s`=1 enters DECODE.
- Cycle counts are edges from the `s`-sampling edge until `w` is 1 again:
  - MOV imm: 3
  - CMP: 5
  - MOV reg / MVN: 5
  - ADD / AND: 6
  - illegal: 2
- Strobes are asserted for exactly one cycle per instruction. `write` is never asserted in the same cycle as `loada`, `loadb` or `loadc`.

## Configuration
- With `CTRL_ILLEGAL_FLAG_EN` defined:
  - Port `illegal` exists.
  - It is registered and set on the DECODE→WAIT transition for an unsupported `ir_op`.
  - It stays 1 until the next WAIT→DECODE transition or reset.
- Without it, there is no `illegal` port and illegal opcodes are silently dropped. All other behaviour is identical.

## Test plan
- Reset mid-instruction: assert `rst_n`=0 while in the ALU state → `loadc` drops within the same cycle, `w`=1, and the state is WAIT after release.
- MOV imm: `fsm_in`=`11010`, pulse `s` → one cycle with `nsel`=100, `vsel`=10, `write`=1; `w`=1 three edges after the `s` edge.
- ADD: `fsm_in`=`10100`; change `fsm_in` to `00000` after DECODE → strobes follow loada/100, loadb/001, loadc (`asel`=0), write/010 (`vsel`=00); 6 cycles total; the change in `fsm_in` has no effect.
- CMP, then MVN back-to-back with `s` held high:
  - CMP: `loads`=1 with `loadc` in ALU, no `write`, 5 cycles.
  - MVN: GET_A is skipped and `asel`=1 in ALU.
- Illegal `fsm_in`=`11111` → no strobes, `w` returns after 2 cycles; with `CTRL_ILLEGAL_FLAG_EN`, `illegal`=1 until the next start.
- `s` pulsed while busy (in GET_B) → ignored; the instruction count is unchanged.

Source files
------------

// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - instruction sequencing FSM for the simple RISC datapath (optional CTRL_ILLEGAL_FLAG_EN adds the illegal flag port)
module cpu_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s,
    input  logic [4:0] fsm_in,
    output logic       w,
    output logic [2:0] nsel,
    output logic [1:0] vsel,
    output logic       write,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
`ifdef CTRL_ILLEGAL_FLAG_EN
    output logic       illegal,
`endif
    output logic       bsel
);

    localparam logic [4:0] OP_MOV_IMM = 5'b110_10;
    localparam logic [4:0] OP_MOV_REG = 5'b110_00;
    localparam logic [4:0] OP_ADD     = 5'b101_00;
    localparam logic [4:0] OP_CMP     = 5'b101_01;
    localparam logic [4:0] OP_AND     = 5'b101_10;
    localparam logic [4:0] OP_MVN     = 5'b101_11;

    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_RM   = 3'b001;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RN   = 3'b100;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_IMM8  = 2'b10;

    typedef enum logic [2:0] {
        ST_WAIT   = 3'd0,
        ST_DECODE = 3'd1,
        ST_WR_IMM = 3'd2,
        ST_GET_A  = 3'd3,
        ST_GET_B  = 3'd4,
        ST_ALU    = 3'd5,
        ST_WR_REG = 3'd6
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [4:0] ir_op;

    // State register; the opcode is latched as the machine leaves WAIT so the decoder may move on
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_WAIT;
            ir_op <= 5'b00000;
        end else begin
            state <= next_state;
            if (state == ST_WAIT && s) begin
                ir_op <= fsm_in;
            end
        end
    end

    // Next-state selection and Moore output decode (ir_op is registered, so outputs stay glitch-free)
    always_comb begin
        next_state = state;
        w          = 1'b0;
        nsel       = NSEL_NONE;
        vsel       = VSEL_C;
        write      = 1'b0;
        loada      = 1'b0;
        loadb      = 1'b0;
        loadc      = 1'b0;
        loads      = 1'b0;
        asel       = 1'b0;
        bsel       = 1'b0;
        case (state)
            ST_WAIT: begin
                w = 1'b1;
                if (s) begin
                    next_state = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (ir_op)
                    OP_MOV_IMM:              next_state = ST_WR_IMM;
                    OP_ADD, OP_CMP, OP_AND:  next_state = ST_GET_A;
                    OP_MOV_REG, OP_MVN:      next_state = ST_GET_B;
                    default:                 next_state = ST_WAIT;
                endcase
            end
            ST_WR_IMM: begin
                nsel       = NSEL_RN;
                vsel       = VSEL_IMM8;
                write      = 1'b1;
                next_state = ST_WAIT;
            end
            ST_GET_A: begin
                nsel       = NSEL_RN;
                loada      = 1'b1;
                next_state = ST_GET_B;
            end
            ST_GET_B: begin
                nsel       = NSEL_RM;
                loadb      = 1'b1;
                next_state = ST_ALU;
            end
            ST_ALU: begin
                loadc = 1'b1;
                // Single-operand ops pass B through the ALU with A forced to zero
                asel  = (ir_op == OP_MOV_REG) || (ir_op == OP_MVN);
                loads = (ir_op == OP_CMP);
                next_state = (ir_op == OP_CMP) ? ST_WAIT : ST_WR_REG;
            end
            ST_WR_REG: begin
                nsel       = NSEL_RD;
                vsel       = VSEL_C;
                write      = 1'b1;
                next_state = ST_WAIT;
            end
            default: begin
                next_state = ST_WAIT;
            end
        endcase
    end

`ifdef CTRL_ILLEGAL_FLAG_EN
    // Sticky illegal-opcode flag: set when DECODE bails out to WAIT, cleared by the next start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal <= 1'b0;
        end else if (state == ST_WAIT && s) begin
            illegal <= 1'b0;
        end else if (state == ST_DECODE && next_state == ST_WAIT) begin
            illegal <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_controller.sv
// tb/tb_cpu_controller.sv - directed self-checking bench for cpu_controller
module tb_cpu_controller;

    logic       clk;
    logic       rst_n;
    logic       s;
    logic [4:0] fsm_in;
    logic       w;
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       write, loada, loadb, loadc, loads, asel, bsel;
`ifdef CTRL_ILLEGAL_FLAG_EN
    logic       illegal;
`endif

    int errors = 0;
    int checks = 0;

    // {w, nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel}
    localparam logic [12:0] O_IDLE  = 13'b1_000_00_0000000;
    localparam logic [12:0] O_DEC   = 13'b0_000_00_0000000;
    localparam logic [12:0] O_WRIMM = 13'b0_100_10_1000000;
    localparam logic [12:0] O_GETA  = 13'b0_100_00_0100000;
    localparam logic [12:0] O_GETB  = 13'b0_001_00_0010000;
    localparam logic [12:0] O_ALU   = 13'b0_000_00_0001000;
    localparam logic [12:0] O_ALUC  = 13'b0_000_00_0001100;
    localparam logic [12:0] O_ALUA  = 13'b0_000_00_0001010;
    localparam logic [12:0] O_WRREG = 13'b0_010_00_1000000;
    localparam logic [12:0] O_Z     = 13'b0;

    logic [12:0] outs;
    assign outs = {w, nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel};

    cpu_controller dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .s      (s),
        .fsm_in (fsm_in),
        .w      (w),
        .nsel   (nsel),
        .vsel   (vsel),
        .write  (write),
        .loada  (loada),
        .loadb  (loadb),
        .loadc  (loadc),
        .loads  (loads),
        .asel   (asel),
`ifdef CTRL_ILLEGAL_FLAG_EN
        .illegal(illegal),
`endif
        .bsel   (bsel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Starts at a negedge; trace holds up to six per-cycle output words, first cycle in the MSBs
    task automatic run(input string tag, input logic [4:0] op, input int n,
                       input logic hold, input logic [4:0] next_op,
                       input int pulse_at, input logic [77:0] trace);
        fsm_in = op;
        s      = 1'b1;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (i == 1) fsm_in = next_op;
            check($sformatf("%s_c%0d", tag, i), {19'b0, outs}, {19'b0, trace[(6-i)*13 +: 13]});
            s = (i == pulse_at) ? 1'b1 : hold;
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        s      = 1'b0;
        fsm_in = 5'b00000;
        repeat (2) @(negedge clk);
        check("reset_outs", {19'b0, outs}, {19'b0, O_IDLE});
`ifdef CTRL_ILLEGAL_FLAG_EN
        check("reset_illegal", {31'b0, illegal}, 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_no_start", {19'b0, outs}, {19'b0, O_IDLE});

        run("mov_imm", 5'b11010, 3, 1'b0, 5'b00000, 0,
            {O_DEC, O_WRIMM, O_IDLE, O_Z, O_Z, O_Z});

        // ADD with fsm_in cleared after capture and a stray s pulse while in GET_B
        run("add", 5'b10100, 6, 1'b0, 5'b00000, 3,
            {O_DEC, O_GETA, O_GETB, O_ALU, O_WRREG, O_IDLE});
        @(negedge clk);
        check("busy_s_ignored", {19'b0, outs}, {19'b0, O_IDLE});

        run("and", 5'b10110, 6, 1'b0, 5'b00000, 0,
            {O_DEC, O_GETA, O_GETB, O_ALU, O_WRREG, O_IDLE});

        run("mov_reg", 5'b11000, 5, 1'b0, 5'b00000, 0,
            {O_DEC, O_GETB, O_ALUA, O_WRREG, O_IDLE, O_Z});

        // CMP then MVN back-to-back with s held; MVN is presented during CMP
        run("cmp", 5'b10101, 5, 1'b1, 5'b10111, 0,
            {O_DEC, O_GETA, O_GETB, O_ALUC, O_IDLE, O_Z});
        run("mvn", 5'b10111, 5, 1'b0, 5'b00000, 0,
            {O_DEC, O_GETB, O_ALUA, O_WRREG, O_IDLE, O_Z});

        run("illegal", 5'b11111, 2, 1'b0, 5'b00000, 0,
            {O_DEC, O_IDLE, O_Z, O_Z, O_Z, O_Z});
`ifdef CTRL_ILLEGAL_FLAG_EN
        check("illegal_set", {31'b0, illegal}, 32'd1);
        @(negedge clk);
        check("illegal_sticky", {31'b0, illegal}, 32'd1);
        run("after_illegal", 5'b11010, 1, 1'b0, 5'b00000, 0,
            {O_DEC, O_Z, O_Z, O_Z, O_Z, O_Z});
        check("illegal_cleared", {31'b0, illegal}, 32'd0);
        repeat (2) @(negedge clk);
        check("after_illegal_done", {19'b0, outs}, {19'b0, O_IDLE});
`endif

        // Reset asserted while in ALU: strobes must drop without waiting for a clock
        run("rst_add", 5'b10100, 4, 1'b0, 5'b00000, 0,
            {O_DEC, O_GETA, O_GETB, O_ALU, O_Z, O_Z});
        #1 rst_n = 1'b0;
        #1 check("rst_async_loadc", {31'b0, loadc}, 32'd0);
        check("rst_async_outs", {19'b0, outs}, {19'b0, O_IDLE});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_idle", {19'b0, outs}, {19'b0, O_IDLE});
        @(negedge clk);
        check("rst_no_write", {19'b0, outs}, {19'b0, O_IDLE});

        run("post_rst_mov", 5'b11010, 3, 1'b0, 5'b00000, 0,
            {O_DEC, O_WRIMM, O_IDLE, O_Z, O_Z, O_Z});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
